// File: rtl/render_reg_commit_queue_if.sv
// rtl/render_reg_commit_queue_if.sv - game-logic register-write bus into the commit queue
interface render_reg_commit_queue_if;
  logic        iWrite;
  logic [3:0]  iRegSel;
  logic [16:0] iData;
  logic        oReady;

  modport master (output iWrite, output iRegSel, output iData, input oReady);
  modport slave  (input iWrite, input iRegSel, input iData, output oReady);
endinterface

// File: rtl/render_reg_commit_queue.sv
// rtl/render_reg_commit_queue.sv - shadow register file committed to the render controller at frame start
module render_reg_commit_queue #(
  parameter int SCREEN_PIXELS = 307200
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  render_reg_commit_queue_if.slave bus,
  input  logic [18:0]           iAddress,
  output logic                  oCommitDone,
  output logic [15:0]           oFrameCount,
  output logic                  oWScreen,
  output logic                  oWBGScroll,
  output logic                  oWBirdY,
  output logic                  oWScore,
  output logic                  oWPipe1X,
  output logic                  oWPipe1Y,
  output logic                  oWPipe2X,
  output logic                  oWPipe2Y,
  output logic                  oWPipe3X,
  output logic                  oWPipe3Y,
  output logic [1:0]            oScreen,
  output logic                  oBGScroll,
  output logic [15:0]           oScore,
  output logic signed [16:0]    oBirdY,
  output logic signed [16:0]    oPipe1X,
  output logic signed [16:0]    oPipe1Y,
  output logic signed [16:0]    oPipe2X,
  output logic signed [16:0]    oPipe2Y,
  output logic signed [16:0]    oPipe3X,
  output logic signed [16:0]    oPipe3Y
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_t;

  localparam logic [3:0] SEL_COMMIT = 4'd15;
  localparam int         NUM_REGS   = 10;

  state_t      r_state;
  state_t      w_next;
  logic [18:0] r_prev_addr;
  logic [15:0] r_frames;
  logic [16:0] r_shadow [NUM_REGS];
  logic [16:0] r_out    [NUM_REGS];
  logic [9:0]  r_dirty;
  logic [9:0]  r_strobe;
  logic        r_done;

  logic        w_ready;
  logic        w_accept;
  logic        w_commit;
  logic        w_frame_start;
  logic        w_issue;
  logic [9:0]  w_wr_mask;
  logic        w_addr_in_frame;
  logic        w_unused;

  // Handshake and frame-boundary decode
  always_comb begin
    w_ready       = (r_state != ST_WAIT);
    w_accept      = bus.iWrite & w_ready;
    w_commit      = w_accept & (bus.iRegSel == SEL_COMMIT);
    w_frame_start = (iAddress == 19'd0) && (r_prev_addr != 19'd0);
    w_issue       = (r_state == ST_WAIT) && w_frame_start;
    w_wr_mask     = 10'd0;
    if (w_accept && (bus.iRegSel < 4'd10)) begin
      w_wr_mask = 10'd1 << bus.iRegSel;
    end
  end

  assign bus.oReady = w_ready;

  // Commit state register
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Commit next-state: a COMMIT accepted during ISSUE is not re-armed; ISSUE always drains to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_commit) w_next = ST_WAIT;
      ST_WAIT:  if (w_frame_start) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Frame tracking; previous address resets nonzero so address 0 right after reset is a frame start
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_prev_addr <= 19'd1;
      r_frames    <= 16'd0;
    end else begin
      r_prev_addr <= iAddress;
      if (w_frame_start) r_frames <= r_frames + 16'd1;
    end
  end

  // Shadow registers and dirty bits; writes are impossible on the issue edge (oReady is low in WAIT)
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_dirty <= 10'd0;
      for (int k = 0; k < NUM_REGS; k++) r_shadow[k] <= 17'd0;
    end else begin
      if (w_issue) r_dirty <= 10'd0;
      else         r_dirty <= r_dirty | w_wr_mask;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_mask[k]) r_shadow[k] <= bus.iData;
      end
    end
  end

  // Registered strobes and data toward the render controller
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_strobe <= 10'd0;
      r_done   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_out[k] <= 17'd0;
    end else begin
      r_strobe <= w_issue ? r_dirty : 10'd0;
      r_done   <= w_issue;
      if (w_issue) begin
        for (int k = 0; k < NUM_REGS; k++) r_out[k] <= r_shadow[k];
      end
    end
  end

  assign oCommitDone = r_done;
  assign oFrameCount = r_frames;
  assign {oWPipe3Y, oWPipe3X, oWPipe2Y, oWPipe2X, oWPipe1Y,
          oWPipe1X, oWScore, oWBirdY, oWBGScroll, oWScreen} = r_strobe;
  assign oScreen   = r_out[0][1:0];
  assign oBGScroll = r_out[1][0];
  assign oBirdY    = r_out[2];
  assign oScore    = r_out[3][15:0];
  assign oPipe1X   = r_out[4];
  assign oPipe1Y   = r_out[5];
  assign oPipe2X   = r_out[6];
  assign oPipe2Y   = r_out[7];
  assign oPipe3X   = r_out[8];
  assign oPipe3Y   = r_out[9];

  // Addresses past the last pixel are not expected from the VGA scanner and are otherwise ignored
  assign w_addr_in_frame = ({13'd0, iAddress} < 32'(SCREEN_PIXELS));
  assign w_unused = &{1'b0, r_out[0][16:2], r_out[1][16:1], r_out[3][16], w_addr_in_frame};

endmodule

// File: tb/tb_render_reg_commit_queue.sv
// tb/tb_render_reg_commit_queue.sv - scoreboard bench for render_reg_commit_queue
module tb_render_reg_commit_queue;

  localparam int SCREEN_PIXELS = 307200;

  logic        iClock;
  logic        iResetN;
  logic [18:0] iAddress;
  logic        oCommitDone;
  logic [15:0] oFrameCount;
  logic        oWScreen, oWBGScroll, oWBirdY, oWScore, oWPipe1X;
  logic        oWPipe1Y, oWPipe2X, oWPipe2Y, oWPipe3X, oWPipe3Y;
  logic [1:0]  oScreen;
  logic        oBGScroll;
  logic [15:0] oScore;
  logic signed [16:0] oBirdY, oPipe1X, oPipe1Y, oPipe2X, oPipe2Y, oPipe3X, oPipe3Y;

  render_reg_commit_queue_if bus();

  render_reg_commit_queue #(.SCREEN_PIXELS(SCREEN_PIXELS)) dut (
    .iClock(iClock), .iResetN(iResetN), .bus(bus.slave), .iAddress(iAddress),
    .oCommitDone(oCommitDone), .oFrameCount(oFrameCount),
    .oWScreen(oWScreen), .oWBGScroll(oWBGScroll), .oWBirdY(oWBirdY), .oWScore(oWScore),
    .oWPipe1X(oWPipe1X), .oWPipe1Y(oWPipe1Y), .oWPipe2X(oWPipe2X), .oWPipe2Y(oWPipe2Y),
    .oWPipe3X(oWPipe3X), .oWPipe3Y(oWPipe3Y),
    .oScreen(oScreen), .oBGScroll(oBGScroll), .oScore(oScore), .oBirdY(oBirdY),
    .oPipe1X(oPipe1X), .oPipe1Y(oPipe1Y), .oPipe2X(oPipe2X), .oPipe2Y(oPipe2Y),
    .oPipe3X(oPipe3X), .oPipe3Y(oPipe3Y)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [9:0]       mask;
    logic [9:0][16:0] vals;
  } exp_t;

  exp_t             sb[$];
  exp_t             e_mon;
  logic [9:0][16:0] m_shadow;
  logic [9:0][16:0] m_out;
  logic [9:0]       m_dirty;
  int               m_fc;
  int               n_checks;
  int               n_errors;
  int               n_done;
  int               n_exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] fit(input int sel, input logic [16:0] d);
    case (sel)
      0:       return d & 17'h3;
      1:       return d & 17'h1;
      3:       return d & 17'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [9:0] obs_strobes();
    return {oWPipe3Y, oWPipe3X, oWPipe2Y, oWPipe2X, oWPipe1Y,
            oWPipe1X, oWScore, oWBirdY, oWBGScroll, oWScreen};
  endfunction

  function automatic logic [9:0][16:0] obs_data();
    logic [9:0][16:0] v;
    v[0] = {15'd0, oScreen};
    v[1] = {16'd0, oBGScroll};
    v[2] = oBirdY;
    v[3] = {1'b0, oScore};
    v[4] = oPipe1X;
    v[5] = oPipe1Y;
    v[6] = oPipe2X;
    v[7] = oPipe2Y;
    v[8] = oPipe3X;
    v[9] = oPipe3Y;
    return v;
  endfunction

  // Commit monitor: every oCommitDone pulse pops one expected commit
  always @(negedge iClock) begin
    if (iResetN === 1'b1) begin
      if (oCommitDone === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          logic [9:0][16:0] d;
          e_mon = sb.pop_front();
          d = obs_data();
          check("strobes", {22'd0, obs_strobes()}, {22'd0, e_mon.mask});
          for (int k = 0; k < 10; k++) begin
            check($sformatf("data%0d", k), {15'd0, d[k]}, {15'd0, e_mon.vals[k]});
          end
        end
      end else if (obs_strobes() != 10'd0) begin
        check("stray_strobe", {22'd0, obs_strobes()}, 32'd0);
      end
    end
  end

  task automatic model_reset();
    n_exp_done = n_exp_done - sb.size();
    sb.delete();
    m_shadow = '0;
    m_out    = '0;
    m_dirty  = '0;
    m_fc     = 0;
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [16:0] data);
    int n;
    bit acc;
    exp_t e;
    n = 0;
    acc = 1'b0;
    bus.iWrite  = 1'b1;
    bus.iRegSel = sel;
    bus.iData   = data;
    while (!acc && n < 2000) begin
      acc = bus.oReady;
      @(posedge iClock);
      #1;
      n++;
    end
    bus.iWrite = 1'b0;
    if (!acc) begin
      check("write_timeout", 32'd0, 32'd1);
    end else if (sel < 4'd10) begin
      m_shadow[sel] = fit(int'(sel), data);
      m_dirty[sel]  = 1'b1;
    end else if (sel == 4'd15) begin
      for (int k = 0; k < 10; k++) if (m_dirty[k]) m_out[k] = m_shadow[k];
      e.mask  = m_dirty;
      e.vals  = m_out;
      m_dirty = '0;
      sb.push_back(e);
      n_exp_done++;
    end
  endtask

  task automatic frame_start();
    iAddress = 19'(SCREEN_PIXELS - 1);
    @(posedge iClock); #1;
    iAddress = 19'd0;
    m_fc++;
    @(posedge iClock); #1;
    iAddress = 19'd1;
    @(posedge iClock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; n_done = 0; n_exp_done = 0;
    bus.iWrite = 1'b0; bus.iRegSel = 4'd0; bus.iData = 17'd0;
    iAddress = 19'd5;
    iResetN  = 1'b0;
    model_reset();
    repeat (3) @(posedge iClock);
    #1;
    iResetN = 1'b1;
    check("rst_ready", {31'd0, bus.oReady}, 32'd1);
    check("rst_frames", {16'd0, oFrameCount}, 32'd0);
    check("rst_done", {31'd0, oCommitDone}, 32'd0);
    check("rst_strobes", {22'd0, obs_strobes()}, 32'd0);
    check("rst_birdy", {15'd0, oBirdY}, 32'd0);
    @(posedge iClock); #1;

    // Basic commit
    do_write(4'd2, 17'd200);
    do_write(4'd15, 17'd0);
    check("wait_ready", {31'd0, bus.oReady}, 32'd0);
    frame_start();
    check("basic_frames", {16'd0, oFrameCount}, 32'(m_fc));

    // Last value wins
    do_write(4'd4, 17'h1FFCC);
    do_write(4'd4, 17'd600);
    do_write(4'd15, 17'd0);
    frame_start();

    // Stall while pending
    do_write(4'd15, 17'd0);
    fork
      do_write(4'd3, 17'd7);
      begin
        repeat (3) begin
          check("stall_ready", {31'd0, bus.oReady}, 32'd0);
          @(posedge iClock); #1;
        end
        frame_start();
      end
    join
    check("stall_dirty_model", {22'd0, m_dirty}, 32'h8);
    do_write(4'd15, 17'd0);
    frame_start();

    // Frame start held for several cycles counts once
    iAddress = 19'd10;
    @(posedge iClock); #1;
    iAddress = 19'd0;
    m_fc++;
    repeat (5) begin @(posedge iClock); #1; end
    iAddress = 19'd10;
    @(posedge iClock); #1;
    check("hold_frames", {16'd0, oFrameCount}, 32'(m_fc));

    // COMMIT on the same edge as a frame start waits for the next one
    do_write(4'd9, 17'h1ABCD);
    iAddress = 19'(SCREEN_PIXELS - 1);
    @(posedge iClock); #1;
    iAddress = 19'd0;
    m_fc++;
    do_write(4'd15, 17'd0);
    iAddress = 19'd1;
    repeat (2) begin
      check("same_edge_no_done", {31'd0, oCommitDone}, 32'd0);
      check("same_edge_pending", {31'd0, bus.oReady}, 32'd0);
      @(posedge iClock); #1;
    end
    frame_start();

    // Reserved code then an empty commit
    do_write(4'd12, 17'h1FFFF);
    do_write(4'd15, 17'd0);
    frame_start();
    check("frames_before_reset", {16'd0, oFrameCount}, 32'(m_fc));

    // Reset during WAIT aborts the commit
    do_write(4'd0, 17'd2);
    do_write(4'd15, 17'd0);
    iAddress = 19'd100;
    repeat (2) begin @(posedge iClock); #1; end
    iResetN = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, bus.oReady}, 32'd1);
    check("rst_mid_strobes", {22'd0, obs_strobes()}, 32'd0);
    model_reset();
    repeat (2) @(posedge iClock);
    #1;
    iResetN = 1'b1;
    frame_start();
    check("rst_screen", {30'd0, oScreen}, 32'd0);
    check("rst_ready_after", {31'd0, bus.oReady}, 32'd1);
    check("rst_frames_after", {16'd0, oFrameCount}, 32'd1);
    check("rst_frames_model", {16'd0, oFrameCount}, 32'(m_fc));

    repeat (3) begin @(posedge iClock); #1; end
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("commit_count", 32'(n_done), 32'(n_exp_done));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
